// File: rtl/spell_mem_arbiter_pkg.sv
// Shared types and constants for the spell memory arbiter: memory-space
// codes (matching the memory model), FSM states and grant identifiers.
package spell_mem_arbiter_pkg;

  // Memory-space codes understood by the spell memory model.
  localparam logic [1:0] MemoryTypeData = 2'b00;
  localparam logic [1:0] MemoryTypeCode = 2'b01;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_id_t;

  // Only the two defined spaces may ever reach the memory.
  function automatic logic space_is_legal(input logic [1:0] space);
    return (space == MemoryTypeData) || (space == MemoryTypeCode);
  endfunction

endpackage

// File: rtl/spell_mem_arbiter_rr.sv
// Two-way round-robin picker: a lone requester wins outright; when both
// request, the port that was not granted last wins.
module spell_mem_arbiter_rr
  import spell_mem_arbiter_pkg::*;
(
  input  logic      i_req_fetch,
  input  logic      i_req_data,
  input  grant_id_t i_last,
  output logic      o_valid,
  output grant_id_t o_grant
);

  // Pure combinational pick; the caller decides when to act on it.
  always_comb begin
    o_valid = i_req_fetch | i_req_data;
    o_grant = GNT_FETCH;
    if (i_req_fetch && i_req_data) begin
      o_grant = (i_last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (i_req_data) begin
      o_grant = GNT_DATA;
    end
  end

endmodule

// File: rtl/spell_mem_arbiter.sv
// Merges the fetch port and the load/store port onto the single
// select/ready memory handshake. One access at a time, a guaranteed
// select-low cycle between accesses, round-robin fairness and a timeout
// that aborts accesses the memory never completes.
module spell_mem_arbiter
  import spell_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       fetch_req,
  input  logic [7:0] fetch_addr,
  output logic       fetch_ack,
  output logic [7:0] fetch_data,
  input  logic       data_req,
  input  logic       data_write,
  input  logic [1:0] data_space,
  input  logic [7:0] data_addr,
  input  logic [7:0] data_wdata,
  output logic       data_ack,
  output logic [7:0] data_rdata,
  output logic       err,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic [1:0] mem_memory_type,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,
  output logic       busy
);

  // The counter holds (cycles spent in ACCESS - 1) before each edge, so an
  // abort at this value lands exactly TIMEOUT_CYCLES edges after the grant.
  localparam logic [7:0] LP_COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t r_state, w_state_next;
  grant_id_t  r_gnt, w_gnt_next;
  grant_id_t  r_last, w_last_next;
  logic [7:0] r_count, w_count_next;
  logic       r_mem_select, w_mem_select_next;
  logic [7:0] r_mem_addr, w_mem_addr_next;
  logic [7:0] r_mem_data_in, w_mem_data_in_next;
  logic [1:0] r_mem_type, w_mem_type_next;
  logic       r_mem_write, w_mem_write_next;
  logic       r_fetch_ack, w_fetch_ack_next;
  logic [7:0] r_fetch_data, w_fetch_data_next;
  logic       r_data_ack, w_data_ack_next;
  logic [7:0] r_data_rdata, w_data_rdata_next;
  logic       r_err, w_err_next;
  logic [7:0] w_result;
  logic       w_rr_valid;
  grant_id_t  w_rr_grant;

  spell_mem_arbiter_rr u_rr (
    .i_req_fetch (fetch_req),
    .i_req_data  (data_req),
    .i_last      (r_last),
    .o_valid     (w_rr_valid),
    .o_grant     (w_rr_grant)
  );

  // Next-state and next-output logic; every register holds unless changed,
  // while acks and err default low so they only ever pulse for one cycle.
  always_comb begin
    w_state_next       = r_state;
    w_gnt_next         = r_gnt;
    w_last_next        = r_last;
    w_count_next       = r_count;
    w_mem_select_next  = r_mem_select;
    w_mem_addr_next    = r_mem_addr;
    w_mem_data_in_next = r_mem_data_in;
    w_mem_type_next    = r_mem_type;
    w_mem_write_next   = r_mem_write;
    w_fetch_ack_next   = 1'b0;
    w_data_ack_next    = 1'b0;
    w_err_next         = 1'b0;
    w_fetch_data_next  = r_fetch_data;
    w_data_rdata_next  = r_data_rdata;
    w_result           = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_valid) begin
          if (w_rr_grant == GNT_FETCH) begin
            // Fetch is a code-space read by construction.
            w_gnt_next        = GNT_FETCH;
            w_mem_addr_next   = fetch_addr;
            w_mem_type_next   = MemoryTypeCode;
            w_mem_write_next  = 1'b0;
            w_mem_select_next = 1'b1;
            w_count_next      = 8'h00;
            w_state_next      = ST_ACCESS;
          end else if (space_is_legal(data_space)) begin
            w_gnt_next         = GNT_DATA;
            w_mem_addr_next    = data_addr;
            w_mem_data_in_next = data_wdata;
            w_mem_type_next    = data_space;
            w_mem_write_next   = data_write;
            w_mem_select_next  = 1'b1;
            w_count_next       = 8'h00;
            w_state_next       = ST_ACCESS;
          end else begin
            // Illegal space: refused without touching the memory, but it
            // still consumes the data port's turn.
            w_data_ack_next   = 1'b1;
            w_err_next        = 1'b1;
            w_data_rdata_next = 8'h00;
            w_last_next       = GNT_DATA;
          end
        end
      end
      ST_ACCESS: begin
        w_count_next = r_count + 8'd1;
        // Ready takes priority over a timeout landing on the same edge.
        if (mem_data_ready || (r_count == LP_COUNT_LAST)) begin
          if (mem_data_ready && !r_mem_write) begin
            w_result = mem_data_out;
          end
          w_err_next        = ~mem_data_ready;
          w_mem_select_next = 1'b0;
          w_state_next      = ST_IDLE;
          w_last_next       = r_gnt;
          if (r_gnt == GNT_FETCH) begin
            w_fetch_ack_next  = 1'b1;
            w_fetch_data_next = w_result;
          end else begin
            w_data_ack_next   = 1'b1;
            w_data_rdata_next = w_result;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops select without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_gnt         <= GNT_FETCH;
      r_last        <= GNT_DATA;
      r_count       <= 8'h00;
      r_mem_select  <= 1'b0;
      r_mem_addr    <= 8'h00;
      r_mem_data_in <= 8'h00;
      r_mem_type    <= MemoryTypeData;
      r_mem_write   <= 1'b0;
      r_fetch_ack   <= 1'b0;
      r_fetch_data  <= 8'h00;
      r_data_ack    <= 1'b0;
      r_data_rdata  <= 8'h00;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_gnt         <= w_gnt_next;
      r_last        <= w_last_next;
      r_count       <= w_count_next;
      r_mem_select  <= w_mem_select_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_data_in <= w_mem_data_in_next;
      r_mem_type    <= w_mem_type_next;
      r_mem_write   <= w_mem_write_next;
      r_fetch_ack   <= w_fetch_ack_next;
      r_fetch_data  <= w_fetch_data_next;
      r_data_ack    <= w_data_ack_next;
      r_data_rdata  <= w_data_rdata_next;
      r_err         <= w_err_next;
    end
  end

  assign fetch_ack       = r_fetch_ack;
  assign fetch_data      = r_fetch_data;
  assign data_ack        = r_data_ack;
  assign data_rdata      = r_data_rdata;
  assign err             = r_err;
  assign mem_select      = r_mem_select;
  assign mem_addr        = r_mem_addr;
  assign mem_data_in     = r_mem_data_in;
  assign mem_memory_type = r_mem_type;
  assign mem_write       = r_mem_write;
  assign busy            = (r_state == ST_ACCESS);

endmodule
